// File: rtl/tff_seq_pkg.sv
// Shared constants and helpers for the T-flip-flop sequence generator and its controller.
// Sequence: 0 -> 8 -> 5 -> 3 -> 7 -> 2 -> 0; every other code falls back to 0.
package tff_seq_pkg;

  typedef logic [3:0] seq_value_t;
  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t ST_IDLE = 2'd0;
  localparam ctrl_state_t ST_RUN  = 2'd1;
  localparam ctrl_state_t ST_DONE = 2'd2;

  localparam seq_value_t S0 = 4'd0;
  localparam seq_value_t S1 = 4'd8;
  localparam seq_value_t S2 = 4'd5;
  localparam seq_value_t S3 = 4'd3;
  localparam seq_value_t S4 = 4'd7;
  localparam seq_value_t S5 = 4'd2;

  localparam int SEQ_LEN = 6;

  function automatic seq_value_t seq_next(input seq_value_t cur);
    seq_value_t nxt;
    case (cur)
      S0:      nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = S3;
      S3:      nxt = S4;
      S4:      nxt = S5;
      S5:      nxt = S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  function automatic logic seq_is_legal(input seq_value_t cur);
    return (cur == S0) || (cur == S1) || (cur == S2) ||
           (cur == S3) || (cur == S4) || (cur == S5);
  endfunction

endpackage

// File: rtl/tff_seq_core.sv
// Four T flip-flops driven by a decoded toggle vector; seeding and clearing
// take priority over an advance.
module tff_seq_core
  import tff_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  input  logic       load_en,
  input  logic [3:0] load_value,
  input  logic       clear,
  output logic [3:0] value,
  output logic       illegal_hit
);

  seq_value_t next_value;
  logic [3:0] toggle;

  assign next_value  = seq_next(value);
  assign toggle      = value ^ next_value;
  assign illegal_hit = advance & ~seq_is_legal(value);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tff
      logic q_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          q_reg <= 1'b0;
        end else if (clear) begin
          q_reg <= 1'b0;
        end else if (load_en) begin
          q_reg <= load_value[gi];
        end else if (advance) begin
          q_reg <= q_reg ^ toggle[gi];
        end
      end
      assign value[gi] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/tff_seq_controller.sv
// Run control for the sequence generator: free-run for NUM_PERIODS periods,
// single-step, seed, abort, and sticky flagging of advances from unused codes.
module tff_seq_controller
  import tff_seq_pkg::*;
#(
  parameter int NUM_PERIODS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       step_mode,
  input  logic       step,
  input  logic       load_en,
  input  logic [3:0] load_value,
  output logic [3:0] value,
  output logic       valid,
  output logic [7:0] period_count,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam logic [7:0] TARGET = 8'(NUM_PERIODS);

  ctrl_state_t state_reg;
  logic        step_mode_reg;
  logic        valid_reg;
  logic        illegal_reg;
  logic [7:0]  period_count_reg;

  logic        advance;
  logic        core_load;
  logic        illegal_hit;
  logic        wrap;
  logic [7:0]  count_inc;

  assign advance   = (state_reg == ST_RUN) && !abort && (step_mode_reg ? step : 1'b1);
  assign core_load = (state_reg == ST_IDLE) && !abort && load_en;
  assign wrap      = advance && (value == S5);
  assign count_inc = (period_count_reg == 8'hFF) ? 8'hFF : period_count_reg + 8'd1;

  tff_seq_core u_core (
    .clock       (clock),
    .reset       (reset),
    .advance     (advance),
    .load_en     (core_load),
    .load_value  (load_value),
    .clear       (abort),
    .value       (value),
    .illegal_hit (illegal_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      step_mode_reg    <= 1'b0;
      valid_reg        <= 1'b0;
      illegal_reg      <= 1'b0;
      period_count_reg <= 8'd0;
    end else if (abort) begin
      // Illegal flag survives an abort so the cause stays visible.
      state_reg        <= ST_IDLE;
      valid_reg        <= 1'b0;
      period_count_reg <= 8'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          valid_reg <= 1'b0;
          if (!load_en && start) begin
            state_reg        <= ST_RUN;
            step_mode_reg    <= step_mode;
            illegal_reg      <= 1'b0;
            period_count_reg <= 8'd0;
          end
        end
        ST_RUN: begin
          valid_reg <= advance;
          if (illegal_hit) begin
            illegal_reg <= 1'b1;
          end
          if (wrap) begin
            period_count_reg <= count_inc;
            if ((TARGET != 8'd0) && (count_inc == TARGET)) begin
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          valid_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid        = valid_reg;
  assign period_count = period_count_reg;
  assign busy         = (state_reg == ST_RUN);
  assign done         = (state_reg == ST_DONE);
  assign illegal      = illegal_reg;

endmodule
